// File: rtl/delay_probe.sv
// Purpose: round-trip delay probe; launches a step on probe_out and averages the echo arrival count.
// Latency: 2^LOG_SHOTS shots, each (line delay + 2 sync cycles) plus ARM/LAUNCH/NEXT overhead.
// Backpressure: none; start is ignored while busy or disabled, ena low aborts without a done pulse.
module delay_probe #(
  parameter int CNT_W     = 8,
  parameter int TIMEOUT   = 255,
  parameter int LOG_SHOTS = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             ena,
  input  logic             start,
  input  logic             echo_in,
  output logic             probe_out,
  output logic             busy,
  output logic             done,
  output logic             timeout,
  output logic [CNT_W-1:0] delay_cnt
);

  // The accumulator holds the sum of up to 2^LOG_SHOTS counts, each at most
  // TIMEOUT, so CNT_W+LOG_SHOTS bits can never overflow.
  localparam int ACC_W  = CNT_W + LOG_SHOTS;
  // A shot counter is still needed (stuck at zero) when only one shot is taken.
  localparam int SHOT_W = (LOG_SHOTS > 0) ? LOG_SHOTS : 1;

  // The phase timeout decision is taken one cycle early so the counter lands
  // exactly on TIMEOUT in the cycle the result is published.
  localparam logic [CNT_W-1:0]  CNT_LAST  = CNT_W'(TIMEOUT - 1);
  localparam logic [CNT_W-1:0]  CNT_TOP   = CNT_W'(TIMEOUT);
  localparam logic [CNT_W-1:0]  CNT_ONE   = CNT_W'(1);
  localparam logic [SHOT_W-1:0] SHOT_LAST = SHOT_W'((1 << LOG_SHOTS) - 1);
  localparam logic [SHOT_W-1:0] SHOT_ONE  = SHOT_W'(1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_ARM,
    S_LAUNCH,
    S_WAIT,
    S_NEXT,
    S_DONE
  } state_t;

  state_t            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [ACC_W-1:0]  acc_q, acc_d;
  logic [SHOT_W-1:0] shot_q, shot_d;
  logic              probe_q, probe_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;
  logic              timeout_q, timeout_d;
  logic [CNT_W-1:0]  dcnt_q, dcnt_d;

  // echo_in is asynchronous to clk; only echo_s_q is ever used by the FSM.
  logic              echo_meta_q, echo_meta_d;
  logic              echo_s_q, echo_s_d;

  // Two-flop synchronizer stage inputs.
  always_comb begin
    echo_meta_d = echo_in;
    echo_s_d    = echo_meta_q;
  end

  // Synchronizer flops, cleared by reset so a stale echo cannot leak into ARM.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      echo_meta_q <= 1'b0;
      echo_s_q    <= 1'b0;
    end else begin
      echo_meta_q <= echo_meta_d;
      echo_s_q    <= echo_s_d;
    end
  end

  // Next-state and next-output logic for the measurement sequencer.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    acc_d     = acc_q;
    shot_d    = shot_q;
    probe_d   = probe_q;
    busy_d    = busy_q;
    done_d    = 1'b0;
    timeout_d = timeout_q;
    dcnt_d    = dcnt_q;

    unique case (state_q)
      S_IDLE: begin
        probe_d = 1'b0;
        busy_d  = 1'b0;
        if (start && ena) begin
          state_d   = S_ARM;
          busy_d    = 1'b1;
          cnt_d     = '0;
          acc_d     = '0;
          shot_d    = '0;
          timeout_d = 1'b0;
        end
      end

      // Wait for the previous echo to drain before launching a new step.
      S_ARM: begin
        if (!echo_s_q) begin
          state_d = S_LAUNCH;
        end else if (cnt_q == CNT_LAST) begin
          state_d   = S_DONE;
          cnt_d     = CNT_TOP;
          done_d    = 1'b1;
          dcnt_d    = '1;
          timeout_d = 1'b1;
        end else begin
          cnt_d = cnt_q + CNT_ONE;
        end
      end

      S_LAUNCH: begin
        state_d = S_WAIT;
        probe_d = 1'b1;
        cnt_d   = '0;
      end

      // Count cycles from the step until the synchronized echo is seen.
      S_WAIT: begin
        if (echo_s_q) begin
          state_d = S_NEXT;
          probe_d = 1'b0;
          acc_d   = acc_q + ACC_W'(cnt_q);
        end else if (cnt_q == CNT_LAST) begin
          state_d   = S_DONE;
          probe_d   = 1'b0;
          cnt_d     = CNT_TOP;
          done_d    = 1'b1;
          dcnt_d    = '1;
          timeout_d = 1'b1;
        end else begin
          cnt_d = cnt_q + CNT_ONE;
        end
      end

      S_NEXT: begin
        if (shot_q == SHOT_LAST) begin
          state_d = S_DONE;
          done_d  = 1'b1;
          // Dropping the low LOG_SHOTS bits is the truncated average.
          dcnt_d  = acc_q[ACC_W-1:LOG_SHOTS];
        end else begin
          state_d = S_ARM;
          shot_d  = shot_q + SHOT_ONE;
          cnt_d   = '0;
        end
      end

      S_DONE: begin
        state_d = S_IDLE;
        busy_d  = 1'b0;
      end

      default: begin
        state_d = S_IDLE;
        probe_d = 1'b0;
        busy_d  = 1'b0;
      end
    endcase

    // Disable wins over everything: abandon the measurement silently and
    // leave the previous result and its timeout flag untouched.
    if (!ena && (state_q != S_IDLE)) begin
      state_d   = S_IDLE;
      probe_d   = 1'b0;
      busy_d    = 1'b0;
      done_d    = 1'b0;
      timeout_d = timeout_q;
      dcnt_d    = dcnt_q;
    end
  end

  // Sequencer state, datapath and registered outputs.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q   <= S_IDLE;
      cnt_q     <= '0;
      acc_q     <= '0;
      shot_q    <= '0;
      probe_q   <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      timeout_q <= 1'b0;
      dcnt_q    <= '0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      acc_q     <= acc_d;
      shot_q    <= shot_d;
      probe_q   <= probe_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      timeout_q <= timeout_d;
      dcnt_q    <= dcnt_d;
    end
  end

  assign probe_out = probe_q;
  assign busy      = busy_q;
  assign done      = done_q;
  assign timeout   = timeout_q;
  assign delay_cnt = dcnt_q;

endmodule

// File: tb/tb_delay_probe.sv
// Purpose: bench for delay_probe with a shift-register delay line and a phase-level timing model.
// Latency: model predicts every output cycle by cycle from start, line delay and timeout rules.
// Backpressure: none; start pulses while busy and while disabled are expected to be ignored.
module tb_delay_probe;

  localparam int NC     = 4096;
  localparam int TO_CYC = 255;
  localparam int NSHOT  = 4;

  logic       clk = 1'b0;
  logic       rst_n, ena, start, echo_in;
  logic       probe_out, busy, done, timeout;
  logic [7:0] delay_cnt;

  logic       ena0, start0, echo0;
  logic       probe0, busy0, done0, timeout0;
  logic [7:0] delay0;

  always #5 clk = ~clk;

  delay_probe #(.CNT_W(8), .TIMEOUT(TO_CYC), .LOG_SHOTS(2)) dut (
    .clk(clk), .rst_n(rst_n), .ena(ena), .start(start), .echo_in(echo_in),
    .probe_out(probe_out), .busy(busy), .done(done), .timeout(timeout),
    .delay_cnt(delay_cnt)
  );

  delay_probe #(.CNT_W(8), .TIMEOUT(TO_CYC), .LOG_SHOTS(0)) dut0 (
    .clk(clk), .rst_n(rst_n), .ena(ena0), .start(start0), .echo_in(echo0),
    .probe_out(probe0), .busy(busy0), .done(done0), .timeout(timeout0),
    .delay_cnt(delay0)
  );

  // Zero-delay loopback for the single-shot instance.
  assign echo0 = probe0;

  // ---------------- delay line environment ----------------
  int         line_mode = 2;   // 0: shift-register line, 1: tied low, 2: tied high
  int         dly_sel   = 0;   // 0: all 5, 1: alternate 5/6, 2: all 6
  int         meas_base = 0;
  int         shots_seen = 0;
  logic       probe_prev = 1'b0;
  logic [7:0] sr = '0;
  int         k_line, d_line;

  function automatic int shot_delay(input int sel, input int k);
    if (sel == 0) return 5;
    if (sel == 2) return 6;
    return ((k & 1) != 0) ? 6 : 5;
  endfunction

  always @(posedge clk) begin
    sr         <= {sr[6:0], probe_out};
    probe_prev <= probe_out;
    if (probe_out && !probe_prev) shots_seen <= shots_seen + 1;
  end

  always_comb begin
    k_line = shots_seen - 1 - meas_base;
    d_line = shot_delay(dly_sel, k_line);
    if (line_mode == 1)      echo_in = 1'b0;
    else if (line_mode == 2) echo_in = 1'b1;
    else                     echo_in = sr[d_line-1];
  end

  // ---------------- expected waveforms ----------------
  bit         exp_probe [NC];
  bit         exp_busy  [NC];
  bit         exp_done  [NC];
  bit         exp_to    [NC];
  logic [7:0] exp_dcnt  [NC];
  int         shot_l    [NSHOT];
  int         quiet_c = 0;     // first cycle from which the synchronized echo is low

  int cyc = 0;
  int n_cmp = 0;
  int n_err = 0;
  int n_done_seen = 0;
  int last_done = -1;

  task automatic check(input string name, input int act, input int expv);
    n_cmp++;
    if (act != expv) begin
      n_err++;
      $display("FAIL %s at cycle %0d: got %0d, expected %0d", name, cyc, act, expv);
    end
  endtask

  // Advance one cycle and compare every output against the model.
  task automatic tick();
    @(negedge clk);
    cyc++;
    if (cyc >= NC) begin
      $display("FAIL cycle_budget at cycle %0d: got %0d, expected below %0d", cyc, cyc, NC);
      $fatal(1, "cycle budget exhausted");
    end
    check("probe_out", int'(probe_out), int'(exp_probe[cyc]));
    check("busy",      int'(busy),      int'(exp_busy[cyc]));
    check("done",      int'(done),      int'(exp_done[cyc]));
    check("timeout",   int'(timeout),   int'(exp_to[cyc]));
    check("delay_cnt", int'(delay_cnt), int'(exp_dcnt[cyc]));
    if (done) begin
      n_done_seen++;
      last_done = cyc;
    end
  endtask

  task automatic run_to(input int c);
    while (cyc < c) tick();
  endtask

  // Phase-level prediction of one measurement accepted in cycle s.
  task automatic plan(input int s, output int done_c);
    int a, e, l, c, d, acc;
    bit to_hit, fin;
    a = s + 1; acc = 0; to_hit = 0; fin = 0; done_c = 0;
    for (int t = s + 1; t < NC; t++) exp_to[t] = 1'b0;
    for (int k = 0; k < NSHOT && !fin; k++) begin
      if (line_mode == 2) e = a + TO_CYC;
      else                e = (quiet_c > a) ? quiet_c : a;
      if (e - a >= TO_CYC) begin
        done_c = a + TO_CYC; to_hit = 1; fin = 1;
      end else begin
        l = e + 2;
        shot_l[k] = l;
        if (line_mode == 1) begin
          for (int t = l; t < l + TO_CYC; t++) exp_probe[t] = 1'b1;
          done_c = l + TO_CYC; to_hit = 1; fin = 1;
        end else begin
          d = shot_delay(dly_sel, k);
          c = d + 2;
          acc += c;
          for (int t = l; t <= l + c; t++) exp_probe[t] = 1'b1;
          quiet_c = l + c + 1 + d + 2;
          a = l + c + 2;
        end
      end
    end
    if (!fin) done_c = a;
    for (int t = s + 1; t <= done_c; t++) exp_busy[t] = 1'b1;
    exp_done[done_c] = 1'b1;
    for (int t = done_c; t < NC; t++) begin
      exp_dcnt[t] = to_hit ? 8'hFF : 8'(acc >> 2);
      exp_to[t]   = to_hit;
    end
  endtask

  // ena dropped in cycle x: everything stops at x+1 and results are frozen.
  task automatic abort_after(input int x);
    for (int t = x + 1; t < NC; t++) begin
      exp_probe[t] = 1'b0;
      exp_busy[t]  = 1'b0;
      exp_done[t]  = 1'b0;
      exp_dcnt[t]  = exp_dcnt[x];
      exp_to[t]    = exp_to[x];
    end
  endtask

  task automatic pulse_start(output int s, output int dc);
    s = cyc;
    meas_base = shots_seen;
    start = 1'b1;
    plan(s, dc);
    tick();
    start = 1'b0;
  endtask

  int s, dc, d1, d2, x, nd;
  int s0, rise0, n_done0, done0_c;

  initial begin
    for (int t = 0; t < NC; t++) exp_dcnt[t] = 8'h00;
    rst_n = 1'b0; ena = 1'b1; start = 1'b1;
    ena0 = 1'b1; start0 = 1'b0;
    line_mode = 2;

    // Reset with echo high and start high.
    repeat (3) tick();
    rst_n = 1'b0;
    check("rst_probe0", int'(probe0), 0);
    check("rst_delay0", int'(delay0), 0);
    rst_n = 1'b1; start = 1'b0;
    repeat (6) tick();
    check("idle_after_rst_busy", int'(busy), 0);
    line_mode = 0; quiet_c = cyc + 2;
    repeat (10) tick();

    // Single-shot zero-delay loopback.
    s0 = cyc; start0 = 1'b1; tick(); start0 = 1'b0;
    rise0 = -1; n_done0 = 0; done0_c = -1;
    repeat (14) begin
      tick();
      if (probe0 && rise0 < 0) rise0 = cyc;
      if (done0) begin n_done0++; done0_c = cyc; end
    end
    check("lb_probe_rise", rise0 - s0, 3);
    check("lb_done_count", n_done0, 1);
    check("lb_done_at", done0_c - s0, 7);
    check("lb_delay", int'(delay0), 2);
    check("lb_timeout", int'(timeout0), 0);

    // 5-cycle line, 4 shots of 7; a stray start while busy is ignored.
    dly_sel = 0;
    pulse_start(s, dc);
    check("model_shift5_done_at", dc - s, 63);
    run_to(shot_l[0] + 4);
    start = 1'b1; tick(); start = 1'b0;
    run_to(dc + 20);
    check("shift5_done_at", last_done - s, 63);
    check("shift5_delay", int'(delay_cnt), 7);

    // Alternating 5/6: counts 7,8,7,8 -> 30>>2 = 7.
    dly_sel = 1;
    pulse_start(s, dc);
    run_to(dc + 20);
    check("alt_done_at", last_done - s, 66);
    check("alt_delay", int'(delay_cnt), 7);

    // 6-cycle line: 4 shots of 8.
    dly_sel = 2;
    pulse_start(s, dc);
    run_to(dc + 20);
    check("shift6_done_at", last_done - s, 70);
    check("shift6_delay", int'(delay_cnt), 8);

    // start held through DONE: second measurement starts from the next IDLE cycle.
    dly_sel = 0;
    nd = n_done_seen;
    s = cyc; meas_base = shots_seen; start = 1'b1;
    plan(s, d1);
    plan(d1 + 1, d2);
    run_to(d1 + 2);
    start = 1'b0;
    run_to(d2 + 20);
    check("held_done_count", n_done_seen - nd, 2);
    check("held_second_done_at", last_done - s, 131);
    check("held_delay", int'(delay_cnt), 7);

    // Echo tied low: WAIT timeout 255 cycles after the probe rises.
    line_mode = 1; quiet_c = cyc + 2;
    repeat (5) tick();
    pulse_start(s, dc);
    run_to(dc + 5);
    check("wait_to_done_at", last_done - s, 258);
    check("wait_to_delay", int'(delay_cnt), 255);
    check("wait_to_flag", int'(timeout), 1);

    // Echo tied high: ARM timeout, probe never launched; accept clears the flag.
    line_mode = 2;
    repeat (5) tick();
    pulse_start(s, dc);
    check("to_cleared_on_start", int'(timeout), 0);
    run_to(dc + 5);
    check("arm_to_done_at", last_done - s, 256);
    check("arm_to_delay", int'(delay_cnt), 255);
    check("arm_to_flag", int'(timeout), 1);

    // start with ena low in IDLE is ignored.
    line_mode = 0; quiet_c = cyc + 2;
    repeat (10) tick();
    ena = 1'b0; start = 1'b1;
    repeat (3) tick();
    start = 1'b0; ena = 1'b1;
    repeat (3) tick();
    check("ena_low_idle_busy", int'(busy), 0);

    // Abort during WAIT of the second shot, then a clean re-measurement.
    dly_sel = 0;
    pulse_start(s, dc);
    x = shot_l[1] + 2;
    run_to(x);
    nd = n_done_seen;
    ena = 1'b0;
    abort_after(x);
    tick();
    ena = 1'b1;
    check("abort_probe", int'(probe_out), 0);
    check("abort_busy", int'(busy), 0);
    quiet_c = x + 1 + 5 + 2;
    run_to(x + 30);
    check("abort_no_done", n_done_seen - nd, 0);
    check("abort_delay_kept", int'(delay_cnt), 255);
    check("abort_timeout_kept", int'(timeout), 0);
    pulse_start(s, dc);
    run_to(dc + 20);
    check("after_abort_delay", int'(delay_cnt), 7);
    check("after_abort_flag", int'(timeout), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
